adc_avg: RTL
============

# adc_avg

Downstream consumer of the SPI ADC reader. It detects the end of each ADC frame on the reader's chip-select, then captures the 16-bit sample. It accumulates 2^AVG_LOG2 samples and presents their truncated mean to the next stage through a valid/ready handshake. A sticky overrun flag reports averages that were lost because the next stage did not accept them in time.

## Interface
- AVG_LOG2, 3, log2 of the number of samples averaged; legal range 0..8.
- DW, 16, sample width; must match the ADC reader's dout width.

- clk  in  1  system clock; the same clock that drives the ADC reader.
- rst  in  1  asynchronous, active-high reset.
- adc_cs  in  1  ADC reader chip-select; a 0→1 transition marks a completed frame.
- adc_dout  in  DW  ADC reader sample register; stable whenever adc_cs is high.
- clr  in  1  synchronous clear; restarts averaging and drops any pending result.
- avg_dout  out  DW  averaged sample.
- avg_valid  out  1  avg_dout holds an unconsumed result.
- avg_ready  in  1  next stage accepts avg_dout when high together with avg_valid.
- ovf  out  1  sticky flag; set when a result was overwritten before it was accepted.

## Operation
- **Frame strobe.**
  - cs_d is a register of adc_cs; its reset value is 1.
  - stb = adc_cs & ~cs_d, so there is exactly one strobe per frame.
  - The reset value of cs_d guarantees no strobe while adc_cs sits high out of reset.
- **State machine (2 states).**
  - SKIP: entered on reset and on clr. The first stb is discarded, because the reader's first frame after reset carries no valid conversion. That stb moves the machine to ACC.
  - ACC: every stb adds adc_dout to acc and increments cnt.
- **Accumulator.**
  - acc is DW+AVG_LOG2 bits; cnt is AVG_LOG2 bits (a 1-bit dummy when AVG_LOG2=0).
  - On the stb where cnt == 2^AVG_LOG2−1:
    - avg_dout ← (acc + adc_dout) >> AVG_LOG2, truncated (floor).
    - acc ← 0 and cnt ← 0.
    - avg_valid ← 1.
  - cnt wraps to 0 after this stb; the state stays ACC.
- **Handshake.**
  - A transfer occurs on any clk edge where avg_valid & avg_ready.
  - After a transfer, avg_valid ← 0 unless a new result completes on that same edge.
  - avg_dout holds its value until a new result loads; ready alone never changes it.
- **Boundary cases.**
  - New result while avg_valid=1 and avg_ready=0: avg_dout takes the newest value, avg_valid stays 1, ovf ← 1.
  - New result on the same edge as a transfer: the new value loads, avg_valid stays 1, ovf is unchanged.
  - clr together with stb: clr wins and the sample is discarded.
  - clr clears acc, cnt, avg_valid and ovf, and forces SKIP. avg_dout is retained.
  - ovf clears only on rst or clr.
  - AVG_LOG2=0: every non-skipped frame produces a result equal to the raw sample.

## Timing
- **Reset values:** avg_dout=0, avg_valid=0, ovf=0, state=SKIP, acc=0, cnt=0, cs_d=1.
- **Result latency:** avg_valid rises on the clk edge that first samples adc_cs=1 for the completing frame. That is one edge after the reader raises cs.
- **Frame rate:** the reader's minimum frame period (>100 clk) leaves many cycles for the next stage to respond. A next stage holding avg_ready=1 never causes ovf.
- **Reset during operation:** rst asserted mid-accumulation returns all state to reset values immediately. The first frame after rst deasserts is skipped.

## Configuration
- **ADC_AVG_SIGNED_EN defined:**
  - Samples are two's complement and are sign-extended into acc.
  - The final shift is arithmetic, so the floor rounds toward −∞.
  - avg_dout is two's complement.
- **ADC_AVG_SIGNED_EN undefined:**
  - Samples are unsigned (straight binary) and are zero-extended.
  - The final shift is logical.

## Test plan
- **Basic average:** AVG_LOG2=2; send frames with samples 0x1234 (skipped), then 100, 200, 300, 400 → a single avg_valid with avg_dout=250; the skipped sample does not contribute.
- **Unsigned vs signed:** AVG_LOG2=2; samples 0xFFFF, 0xFFFF, 0x0001, 0x0001 → avg_dout=0x8000 without the macro, 0x0000 with ADC_AVG_SIGNED_EN.
- **Truncation:** AVG_LOG2=2; samples 1, 1, 1, 2 → avg_dout=1. With the signed macro, samples −1, −1, −1, −2 → avg_dout=0xFFFE (−2).
- **Overrun:** hold avg_ready=0 across two completed averages of 10 and 20 → avg_dout=20, avg_valid=1, ovf=1. Pulse avg_ready → avg_valid=0 and ovf stays 1. Pulse clr → ovf=0.
- **Simultaneous events:**
  - Raise avg_ready on the exact edge a new result of 7 completes (previous result 5 pending) → 5 is consumed, avg_dout=7, avg_valid stays 1, ovf=0.
  - clr coincident with stb → acc=0, state=SKIP, and the next frame is discarded.
- **Reset mid-accumulation:** assert rst after 2 of 4 samples → all outputs return to 0. After release, the first frame is skipped and the next four samples 8, 8, 8, 8 give avg_dout=8.

Source files
------------

// File: rtl/adc_avg.sv
// adc_avg: averages 2**AVG_LOG2 SPI ADC frames and offers the truncated mean on a valid/ready port.
// Build option ADC_AVG_SIGNED_EN: samples are two's complement (sign-extended, arithmetic shift).
module adc_avg #(
  parameter int AVG_LOG2 = 3,
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adc_cs,
  input  logic [DW-1:0] adc_dout,
  input  logic          clr,
  output logic [DW-1:0] avg_dout,
  output logic          avg_valid,
  input  logic          avg_ready,
  output logic          ovf
);

  localparam int AW = DW + AVG_LOG2;
  localparam int CW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic {
    SKIP = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          cs_d;
  logic          stb;
  logic          take;
  logic          done;
  logic          xfer;
  logic [AW-1:0] acc;
  logic [AW-1:0] sample_ext;
  logic [AW-1:0] sum;
  logic [CW-1:0] cnt;
  logic [DW-1:0] mean;

  // cs_d resets high so a chip-select already idling high gives no strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cs_d <= 1'b1;
    else     cs_d <= adc_cs;
  end

  assign stb  = adc_cs & ~cs_d;
  assign xfer = avg_valid & avg_ready;

`ifdef ADC_AVG_SIGNED_EN
  assign sample_ext = AW'($signed(adc_dout));
  assign sum        = acc + sample_ext;
  assign mean       = DW'($signed(sum) >>> AVG_LOG2);
`else
  assign sample_ext = AW'(adc_dout);
  assign sum        = acc + sample_ext;
  assign mean       = DW'(sum >> AVG_LOG2);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SKIP;
    else     state <= state_nxt;
  end

  // The first frame after reset/clear carries no valid conversion and is dropped
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    if (clr) begin
      state_nxt = SKIP;
    end else if (stb) begin
      case (state)
        SKIP:    state_nxt = ACC;
        ACC:     take      = 1'b1;
        default: state_nxt = SKIP;
      endcase
    end
  end

  assign done = take & (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      avg_dout  <= '0;
      avg_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (clr) begin
      acc       <= '0;
      cnt       <= '0;
      avg_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (done) begin
      acc       <= '0;
      cnt       <= '0;
      avg_dout  <= mean;
      avg_valid <= 1'b1;
      // a pending result that was not taken on this edge is lost
      if (avg_valid & ~avg_ready) ovf <= 1'b1;
    end else begin
      if (take) begin
        acc <= sum;
        cnt <= cnt + CW'(1);
      end
      if (xfer) avg_valid <= 1'b0;
    end
  end

endmodule
